// File: rtl/ev_cmd_arbiter_if.sv
// Purpose : requester-side and core-side signal bundle for the EV command arbiter.
// Latency : none (wires only).
// Backpr. : plc/hmi use valid/ready; a request transfers on the cycle both are high.
// Ports   : plc_* / hmi_* request channels (valid, op[2:0], data[7:0], ready),
//           core_op/core_data/core_strobe to the core, grant_hmi, busy, drop_cnt status.
//           modport slave = arbiter side, modport master = requester/core side.
interface ev_cmd_arbiter_if;
    logic       plc_valid;
    logic [2:0] plc_op;
    logic [7:0] plc_data;
    logic       plc_ready;
    logic       hmi_valid;
    logic [2:0] hmi_op;
    logic [7:0] hmi_data;
    logic       hmi_ready;
    logic [2:0] core_op;
    logic [7:0] core_data;
    logic       core_strobe;
    logic       grant_hmi;
    logic       busy;
    logic [7:0] drop_cnt;

    modport slave (
        input  plc_valid, plc_op, plc_data,
        output plc_ready,
        input  hmi_valid, hmi_op, hmi_data,
        output hmi_ready,
        output core_op, core_data, core_strobe, grant_hmi, busy, drop_cnt
    );

    modport master (
        output plc_valid, plc_op, plc_data,
        input  plc_ready,
        output hmi_valid, hmi_op, hmi_data,
        input  hmi_ready,
        input  core_op, core_data, core_strobe, grant_hmi, busy, drop_cnt
    );
endinterface

// File: rtl/ev_cmd_arbiter.sv
// Purpose : arbitrates PLC/HMI commands onto the motor-core op bus, holding each op DWELL_CYC cycles.
// Latency : accept edge -> core_op valid 1 cycle; next accept possible in first IDLE cycle after dwell.
// Backpr. : readys only in IDLE with ena=1; ena=0 freezes everything; readys gated by rst_n.
// Ports   : clk, rst_n (async, active-low), ena, mode_hmi (preferred side), temp_fault,
//           bus (ev_cmd_arbiter_if.slave): request channels in, core_op/data/strobe, grant_hmi,
//           busy, drop_cnt out.
// Option  : define AUTO_PWM_EN to follow every issued op 4 with an op 5 of the same dwell
//           (skipped if temp_fault is high when the op 4 dwell ends).
module ev_cmd_arbiter #(
    parameter int unsigned DWELL_CYC  = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            mode_hmi,
    input  logic            temp_fault,
    ev_cmd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHAIN = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL_CYC - 1);
    localparam logic [3:0] LIM        = 4'(STARVE_LIM);

    state_t     state_q, state_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] streak_q, streak_d;
    logic       mode_prev_q, mode_prev_d;
    logic [2:0] core_op_q, core_op_d;
    logic [7:0] core_data_q, core_data_d;
    logic       core_strobe_q, core_strobe_d;
    logic       grant_hmi_q, grant_hmi_d;
    logic       busy_q, busy_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    logic       both_vld;
    logic [3:0] streak_eff;
    logic       sel_hmi;
    logic       arb_ok;
    logic       accept;
    logic [2:0] acc_op;
    logic [7:0] acc_data;
    logic       acc_drop;
    logic       chain_go;

    // Arbitration: op 7 outranks everything (PLC on a tie); otherwise the preferred
    // side wins until it has starved the other side STARVE_LIM grants in a row.
    // A preference change restarts the streak in the same cycle it is seen.
    always_comb begin
        both_vld   = bus.plc_valid & bus.hmi_valid;
        streak_eff = (mode_hmi != mode_prev_q) ? 4'd0 : streak_q;
        sel_hmi    = bus.hmi_valid;
        if (both_vld) begin
            if (bus.plc_op == 3'd7) begin
                sel_hmi = 1'b0;
            end else if (bus.hmi_op == 3'd7) begin
                sel_hmi = 1'b1;
            end else if (streak_eff == LIM) begin
                sel_hmi = ~mode_hmi;
            end else begin
                sel_hmi = mode_hmi;
            end
        end
    end

    assign arb_ok        = rst_n & ena & (state_q == S_IDLE);
    assign bus.plc_ready = arb_ok & ~sel_hmi & bus.plc_valid;
    assign bus.hmi_ready = arb_ok &  sel_hmi & bus.hmi_valid;
    assign accept        = bus.plc_ready | bus.hmi_ready;
    assign acc_op        = sel_hmi ? bus.hmi_op   : bus.plc_op;
    assign acc_data      = sel_hmi ? bus.hmi_data : bus.plc_data;
    // Speed/PWM commands are consumed but discarded while the core is overheated.
    assign acc_drop      = temp_fault & ((acc_op == 3'd4) | (acc_op == 3'd5));

`ifdef AUTO_PWM_EN
    assign chain_go = (state_q == S_ISSUE) & (core_op_q == 3'd4) & ~temp_fault;
`else
    assign chain_go = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        streak_d      = streak_q;
        mode_prev_d   = mode_prev_q;
        core_op_d     = core_op_q;
        core_data_d   = core_data_q;
        core_strobe_d = core_strobe_q;
        grant_hmi_d   = grant_hmi_q;
        busy_d        = busy_q;
        drop_cnt_d    = drop_cnt_q;

        if (ena) begin
            core_strobe_d = 1'b0;
            mode_prev_d   = mode_hmi;
            streak_d      = streak_eff;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_hmi_d = sel_hmi;
                        if (sel_hmi != mode_hmi) begin
                            streak_d = 4'd0;
                        end else if (both_vld && (streak_eff != LIM)) begin
                            streak_d = streak_eff + 4'd1;
                        end
                        if (acc_drop) begin
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_d = drop_cnt_q + 8'd1;
                            end
                        end else begin
                            state_d       = S_ISSUE;
                            dwell_d       = DWELL_LAST;
                            core_op_d     = acc_op;
                            core_data_d   = acc_data;
                            core_strobe_d = 1'b1;
                            busy_d        = 1'b1;
                        end
                    end
                end
                S_ISSUE, S_CHAIN: begin
                    if (dwell_q != 4'd0) begin
                        dwell_d = dwell_q - 4'd1;
                    end else if (chain_go) begin
                        state_d       = S_CHAIN;
                        dwell_d       = DWELL_LAST;
                        core_op_d     = 3'd5;
                        core_strobe_d = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        core_op_d = 3'd0;
                        busy_d    = 1'b0;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    core_op_d = 3'd0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dwell_q       <= 4'd0;
            streak_q      <= 4'd0;
            mode_prev_q   <= 1'b0;
            core_op_q     <= 3'd0;
            core_data_q   <= 8'd0;
            core_strobe_q <= 1'b0;
            grant_hmi_q   <= 1'b0;
            busy_q        <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            streak_q      <= streak_d;
            mode_prev_q   <= mode_prev_d;
            core_op_q     <= core_op_d;
            core_data_q   <= core_data_d;
            core_strobe_q <= core_strobe_d;
            grant_hmi_q   <= grant_hmi_d;
            busy_q        <= busy_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.core_op     = core_op_q;
    assign bus.core_data   = core_data_q;
    assign bus.core_strobe = core_strobe_q;
    assign bus.grant_hmi   = grant_hmi_q;
    assign bus.busy        = busy_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ev_cmd_arbiter.sv
// Purpose : self-checking bench for ev_cmd_arbiter against a queue-based reference model.
// Latency : model predicts every cycle; inputs change on negedge, outputs checked on negedge.
// Backpr. : requests are random and need not be held; readys are checked against the model.
module tb_ev_cmd_arbiter;
    localparam int DWELL = 2;
    localparam int LIM   = 4;
`ifdef AUTO_PWM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic mode_hmi;
    logic temp_fault;

    ev_cmd_arbiter_if bus_if ();

    ev_cmd_arbiter #(.DWELL_CYC(DWELL), .STARVE_LIM(LIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode_hmi  (mode_hmi),
        .temp_fault(temp_fault),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds the (op, strobe) pair the core bus shows on each
    // remaining active cycle; an empty queue means the arbiter is idle.
    typedef struct packed {
        logic [2:0] op;
        logic       stb;
    } slot_t;

    slot_t      pend[$];
    bit         m_chain;
    logic [7:0] m_data;
    logic       m_grant;
    int         m_drop;
    int         m_streak;
    logic       m_mode_prev;

    logic t_acc;
    logic t_acc_hmi;

    task automatic model_reset();
        pend.delete();
        m_chain     = 1'b0;
        m_data      = 8'd0;
        m_grant     = 1'b0;
        m_drop      = 0;
        m_streak    = 0;
        m_mode_prev = 1'b0;
    endtask

    function automatic logic m_sel(input logic pv, input logic hv, input logic [2:0] po,
                                   input logic [2:0] ho, input logic md, input int se);
        if (pv && hv) begin
            if (po == 3'd7) return 1'b0;
            if (ho == 3'd7) return 1'b1;
            return (se == LIM) ? !md : md;
        end
        return hv;
    endfunction

    task automatic model_step();
        int         se;
        logic       sel;
        logic [2:0] op;
        logic [7:0] dat;
        slot_t      s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!ena) return;
        se = (mode_hmi != m_mode_prev) ? 0 : m_streak;
        if (pend.size() == 0) begin
            sel = m_sel(bus_if.plc_valid, bus_if.hmi_valid, bus_if.plc_op, bus_if.hmi_op, mode_hmi, se);
            if ((sel && bus_if.hmi_valid) || (!sel && bus_if.plc_valid)) begin
                op  = sel ? bus_if.hmi_op : bus_if.plc_op;
                dat = sel ? bus_if.hmi_data : bus_if.plc_data;
                m_grant = sel;
                if (sel != mode_hmi) se = 0;
                else if (bus_if.plc_valid && bus_if.hmi_valid && se < LIM) se = se + 1;
                if (temp_fault && (op == 3'd4 || op == 3'd5)) begin
                    if (m_drop < 255) m_drop = m_drop + 1;
                end else begin
                    for (int k = 0; k < DWELL; k++) begin
                        s.op  = op;
                        s.stb = (k == 0);
                        pend.push_back(s);
                    end
                    m_data  = dat;
                    m_chain = AUTO && (op == 3'd4);
                end
            end
        end else begin
            void'(pend.pop_front());
            if (pend.size() == 0 && m_chain) begin
                m_chain = 1'b0;
                if (!temp_fault) begin
                    for (int k = 0; k < DWELL; k++) begin
                        s.op  = 3'd5;
                        s.stb = (k == 0);
                        pend.push_back(s);
                    end
                end
            end
        end
        m_streak    = se;
        m_mode_prev = mode_hmi;
    endtask

    // One clock: check readys against the model, advance the model on the edge,
    // then check all registered outputs half a cycle later.
    task automatic tick();
        int   se;
        logic sel;
        logic idle;
        logic epr, ehr;
        #1;
        se   = (mode_hmi != m_mode_prev) ? 0 : m_streak;
        sel  = m_sel(bus_if.plc_valid, bus_if.hmi_valid, bus_if.plc_op, bus_if.hmi_op, mode_hmi, se);
        idle = (pend.size() == 0);
        epr  = rst_n && ena && idle && bus_if.plc_valid && !sel;
        ehr  = rst_n && ena && idle && bus_if.hmi_valid && sel;
        t_acc     = bus_if.plc_ready | bus_if.hmi_ready;
        t_acc_hmi = bus_if.hmi_ready;
        chk("plc_ready", bus_if.plc_ready, epr);
        chk("hmi_ready", bus_if.hmi_ready, ehr);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("core_op",     bus_if.core_op,     (pend.size() == 0) ? 0 : pend[0].op);
        chk("core_strobe", bus_if.core_strobe, (pend.size() == 0) ? 0 : pend[0].stb);
        chk("busy",        bus_if.busy,        (pend.size() != 0));
        chk("core_data",   bus_if.core_data,   m_data);
        chk("grant_hmi",   bus_if.grant_hmi,   m_grant);
        chk("drop_cnt",    bus_if.drop_cnt,    m_drop);
    endtask

    task automatic set_req(input logic pv, input logic [2:0] po, input logic [7:0] pd,
                           input logic hv, input logic [2:0] ho, input logic [7:0] hd);
        bus_if.plc_valid = pv;
        bus_if.plc_op    = po;
        bus_if.plc_data  = pd;
        bus_if.hmi_valid = hv;
        bus_if.hmi_op    = ho;
        bus_if.hmi_data  = hd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus_if.busy && n < 50) begin
            tick();
            n++;
        end
        if (bus_if.busy) chk("wait_idle_timeout", 1, 0);
    endtask

    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int got_order[10];
    int seq_op[5];
    int exp_seq[5];
    int n_stb;
    int cnt;
    int ng;

    initial begin
        model_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        mode_hmi = 1'b0;
        temp_fault = 1'b0;
        set_req(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);

        // Reset with both requesters valid: everything low.
        tick();
        chk("rst_core_op", bus_if.core_op, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_ready", {bus_if.plc_ready, bus_if.hmi_ready}, 0);
        chk("rst_drop", bus_if.drop_cnt, 0);
        rst_n = 1'b1;

        // PLC op 1 alone.
        set_req(1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 8'h00);
        tick();
        chk("t1_plc_ready", t_acc && !t_acc_hmi, 1);
        chk("t1_op_c1", bus_if.core_op, 1);
        chk("t1_stb_c1", bus_if.core_strobe, 1);
        bus_if.plc_valid = 1'b0;
        tick();
        chk("t1_op_c2", bus_if.core_op, 1);
        chk("t1_stb_c2", bus_if.core_strobe, 0);
        tick();
        chk("t1_op_c3", bus_if.core_op, 0);
        chk("t1_busy_c3", bus_if.busy, 0);

        // Starvation limit with HMI preferred.
        do_reset();
        mode_hmi = 1'b1;
        set_req(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02);
        ng = 0;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            tick();
            if (t_acc) begin
                got_order[ng] = t_acc_hmi;
                ng++;
            end
        end
        chk("t2_grants", ng, 10);
        for (int i = 0; i < 10; i++) chk("t2_order", got_order[i], exp_order[i]);
        set_req(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        wait_idle();

        // Op 7 beats the preferred side.
        do_reset();
        mode_hmi = 1'b0;
        set_req(1'b1, 3'd2, 8'h20, 1'b1, 3'd7, 8'h70);
        tick();
        chk("t3_hmi_granted", t_acc_hmi, 1);
        chk("t3_core_op", bus_if.core_op, 7);
        chk("t3_grant_hmi", bus_if.grant_hmi, 1);
        set_req(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        wait_idle();

        // Fault drops and drop counter saturation.
        do_reset();
        temp_fault = 1'b1;
        set_req(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h83);
        tick();
        chk("t4_hmi_ready", t_acc_hmi, 1);
        chk("t4_drop_1", bus_if.drop_cnt, 1);
        chk("t4_core_op", bus_if.core_op, 0);
        for (int i = 0; i < 256; i++) tick();
        chk("t4_drop_sat", bus_if.drop_cnt, 255);
        set_req(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        temp_fault = 1'b0;

        // Op 4 with or without the PWM follow-up.
        do_reset();
        set_req(1'b1, 3'd4, 8'hA2, 1'b0, 3'd0, 8'h00);
        n_stb = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus_if.plc_valid = 1'b0;
            seq_op[i] = bus_if.core_op;
            if (bus_if.core_strobe) n_stb++;
        end
        if (AUTO) begin
            exp_seq = '{4, 4, 5, 5, 0};
        end else begin
            exp_seq = '{4, 4, 0, 0, 0};
        end
        for (int i = 0; i < 5; i++) chk("t5_op_seq", seq_op[i], exp_seq[i]);
        chk("t5_strobes", n_stb, AUTO ? 2 : 1);
        chk("t5_data", bus_if.core_data, 8'hA2);

        // Asynchronous reset during the second dwell cycle.
        do_reset();
        set_req(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00);
        tick();
        bus_if.plc_valid = 1'b0;
        tick();
        chk("t6_pre_op", bus_if.core_op, 6);
        rst_n = 1'b0;
        #1;
        chk("t6_async_op", bus_if.core_op, 0);
        chk("t6_async_busy", bus_if.busy, 0);
        model_reset();
        tick();
        rst_n = 1'b1;

        // ena pause mid-dwell: only enabled cycles count toward the dwell.
        set_req(1'b1, 3'd3, 8'h33, 1'b0, 3'd0, 8'h00);
        tick();
        bus_if.plc_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.core_op == 3'd0) break;
            ena = (i >= 1 && i < 6) ? 1'b0 : 1'b1;
            if (ena) cnt++;
            tick();
        end
        ena = 1'b1;
        chk("t6_dwell_cnt", cnt, DWELL);
        chk("t6_idle_after", bus_if.busy, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode_hmi = ~mode_hmi;
            if ($urandom_range(0, 29) == 0) temp_fault = ~temp_fault;
            set_req(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 8'($urandom),
                    ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 8'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
